// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: one registered req/gnt/rvalid bus transaction per access, 3+ stall cycles.
// Stalls the pipeline until rvalid or timeout; a one-cycle DONE gap releases the instruction.
module mem_stage_lsu #(
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic                  i_mem_write_M,
  input  logic [1:0]            i_result_src_M,
  input  logic [2:0]            i_funct3_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_access_err_M,
  output logic                  o_bus_err_M,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [DATA_WIDTH-1:0] o_bus_addr,
  output logic [3:0]            o_bus_be,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_rvalid,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic [1:0]              off;
  logic                    access, misalign, bad_f3, err, start, timed_out;
  logic [3:0]              be_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_data;

  assign off       = i_alu_result_M[1:0];
  assign access    = i_mem_write_M | (i_result_src_M == 2'b01);
  assign bad_f3    = (i_funct3_M == 3'b011) | (i_funct3_M == 3'b110) | (i_funct3_M == 3'b111);
  assign misalign  = ((i_funct3_M[1:0] == 2'b01) & off[0]) | ((i_funct3_M[1:0] == 2'b10) & (|off));
  assign err       = access & (bad_f3 | misalign);
  assign start     = (state_q == S_IDLE) & access & !err;
  assign timed_out = (WAIT_TIMEOUT != 0) && (cnt_q == CW'(WAIT_TIMEOUT));

  assign o_stall_M      = !rst & (start | (state_q == S_REQ) | (state_q == S_WAIT));
  assign o_access_err_M = !rst & (state_q == S_IDLE) & err;

  // Store lane placement; loads always request the full word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_write_data_M;
    if (i_mem_write_M) begin
      case (i_funct3_M[1:0])
        2'b00: begin
          be_d    = 4'b0001 << off;
          wdata_d = {4{i_write_data_M[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << off;
          wdata_d = {2{i_write_data_M[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign ld_byte = i_bus_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

  always_comb begin
    ld_data = i_bus_rdata;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (i_bus_gnt) state_d = S_WAIT;
      S_WAIT:  if (i_bus_rvalid || timed_out) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_be      <= '0;
      o_bus_wdata   <= '0;
      o_read_data_M <= '0;
      o_bus_err_M   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_write_M;
            o_bus_addr  <= {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
            o_bus_be    <= be_d;
            o_bus_wdata <= wdata_d;
            funct3_q    <= i_funct3_M;
            off_q       <= off;
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            o_bus_req <= 1'b0;
            cnt_q     <= '0;
          end
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle still completes normally.
          if (i_bus_rvalid) begin
            if (!o_bus_we) o_read_data_M <= ld_data;
          end else if (timed_out) begin
            o_bus_err_M <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: o_bus_err_M <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboarded bench: driver pushes expected bus requests, monitor pops on gnt and checks load data.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, wd, rd_data, baddr, bwdata, rdata;
  logic        mw, stall, aerr, berr, breq, bwe, gnt, rvalid;
  logic [1:0]  rs;
  logic [2:0]  f3;
  logic [3:0]  bbe;

  logic [31:0] t_alu, t_rd, t_baddr, t_bwdata;
  logic        t_mw, t_stall, t_aerr, t_berr, t_breq, t_bwe, t_gnt, t_rvalid;
  logic [1:0]  t_rs;
  logic [2:0]  t_f3;
  logic [3:0]  t_bbe;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .i_alu_result_M(alu), .i_write_data_M(wd), .i_mem_write_M(mw),
    .i_result_src_M(rs), .i_funct3_M(f3), .o_read_data_M(rd_data), .o_stall_M(stall),
    .o_access_err_M(aerr), .o_bus_err_M(berr), .o_bus_req(breq), .o_bus_we(bwe),
    .o_bus_addr(baddr), .o_bus_be(bbe), .o_bus_wdata(bwdata), .i_bus_gnt(gnt),
    .i_bus_rvalid(rvalid), .i_bus_rdata(rdata));

  mem_stage_lsu #(.WAIT_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .i_alu_result_M(t_alu), .i_write_data_M(wd), .i_mem_write_M(t_mw),
    .i_result_src_M(t_rs), .i_funct3_M(t_f3), .o_read_data_M(t_rd), .o_stall_M(t_stall),
    .o_access_err_M(t_aerr), .o_bus_err_M(t_berr), .o_bus_req(t_breq), .o_bus_we(t_bwe),
    .o_bus_addr(t_baddr), .o_bus_be(t_bbe), .o_bus_wdata(t_bwdata), .i_bus_gnt(t_gnt),
    .i_bus_rvalid(t_rvalid), .i_bus_rdata(32'h0));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [1:0]  off;
  } exp_t;

  exp_t exp_q[$];

  function automatic int sz(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic model_err(input logic acc, input logic [31:0] a, input logic [2:0] f);
    if (!acc) return 1'b0;
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    return (a % sz(f)) != 0;
  endfunction

  function automatic exp_t model_req(input logic w, input logic [31:0] a, input logic [2:0] f,
                                     input logic [31:0] d);
    exp_t e;
    int   s;
    s       = sz(f);
    e.we    = w;
    e.addr  = a - (a % 4);
    e.off   = 2'(a % 4);
    e.f3    = f;
    e.be    = 4'hf;
    e.wdata = d;
    if (w) begin
      e.be = 4'(((1 << s) - 1) << (a % 4));
      if (s == 1) e.wdata = d[7:0] * 32'h01010101;
      else if (s == 2) e.wdata = d[15:0] * 32'h00010001;
    end
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] r, input logic [2:0] f,
                                             input logic [1:0] off);
    int          s;
    logic [31:0] v, mask;
    s    = sz(f);
    v    = r >> (8 * off);
    mask = (s == 4) ? 32'hffffffff : ((32'd1 << (8 * s)) - 1);
    v    = v & mask;
    if (!f[2] && s < 4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // Bus responder
  bit          bus_auto = 1;
  bit          rand_rd  = 0;
  int          gd_min = 0, gd_max = 0, rv_min = 1, rv_max = 1;
  logic [31:0] fixed_rd = 32'h0;

  initial begin
    int          gd, rv;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    gnt = 0; rvalid = 0; rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (bus_auto && breq && !rst) begin
        gd  = $urandom_range(gd_max, gd_min);
        rv  = $urandom_range(rv_max, rv_min);
        a0  = baddr; w0 = bwdata; b0 = bbe; we0 = bwe;
        repeat (gd) begin
          @(posedge clk); #1;
          chk("req_hold_addr", baddr, a0);
          chk("req_hold_ctl", {27'h0, breq, bwe, bbe}, {27'h0, 1'b1, we0, b0});
          chk("req_hold_wdata", bwdata, w0);
        end
        gnt = 1;
        @(posedge clk); #1;
        gnt = 0;
        repeat (rv - 1) begin @(posedge clk); #1; end
        rvalid = 1;
        rdata  = rand_rd ? $urandom : fixed_rd;
        @(posedge clk); #1;
        rvalid = 0;
        rdata  = $urandom;
      end
    end
  end

  // Monitor
  initial begin
    exp_t        cur;
    bit          pend, chk_nxt;
    logic [31:0] model_rd;
    pend = 0; chk_nxt = 0; model_rd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pend = 0; chk_nxt = 0; model_rd = 0;
      end else begin
        if (chk_nxt) begin
          chk("read_data", rd_data, model_rd);
          chk("done_no_bus_err", {31'h0, berr}, 32'h0);
          chk("done_stall_low", {31'h0, stall}, 32'h0);
          chk_nxt = 0;
        end
        if (breq && gnt) begin
          chk("issue_expected", {31'h0, exp_q.size() > 0}, 32'h1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("bus_addr", baddr, cur.addr);
            chk("bus_we", {31'h0, bwe}, {31'h0, cur.we});
            chk("bus_be", {28'h0, bbe}, {28'h0, cur.be});
            if (cur.we) chk("bus_wdata", bwdata, cur.wdata);
            pend = 1;
          end
        end
        if (rvalid && pend) begin
          if (!cur.we) model_rd = model_load(rdata, cur.f3, cur.off);
          pend    = 0;
          chk_nxt = 1;
        end
      end
    end
  end

  task automatic issue(input logic mwi, input logic [1:0] rsi, input logic [2:0] fi,
                       input logic [31:0] ai, input logic [31:0] di, output int stalls);
    logic acc, e;
    int   guard;
    acc = mwi || (rsi == 2'b01);
    e   = model_err(acc, ai, fi);
    mw = mwi; rs = rsi; f3 = fi; alu = ai; wd = di;
    if (acc && !e) exp_q.push_back(model_req(mwi, ai, fi, di));
    stalls = 0; guard = 0;
    @(negedge clk);
    chk("access_err", {31'h0, aerr}, {31'h0, e});
    chk("stall_start", {31'h0, stall}, {31'h0, acc && !e});
    if (e) chk("err_no_req", {31'h0, breq}, 32'h0);
    while (stall && guard < 200) begin
      stalls++; guard++;
      @(negedge clk);
    end
    chk("stall_released", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    mw = 0; rs = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          st, n;
    logic        m;
    logic [1:0]  r2;
    logic [2:0]  f;
    logic [2:0]  ld_f3 [5];
    logic [2:0]  bad_f3[3];
    ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad_f3 = '{3'd3, 3'd6, 3'd7};
    rst = 1; wd = 0;
    mw = 0; rs = 2'b01; f3 = 3'b010; alu = 32'h100;
    t_mw = 0; t_rs = 0; t_f3 = 0; t_alu = 0; t_gnt = 0; t_rvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, breq}, 32'h0);
    chk("rst_we", {31'h0, bwe}, 32'h0);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_be", {28'h0, bbe}, 32'h0);
    chk("rst_wdata", bwdata, 32'h0);
    chk("rst_rdata", rd_data, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_err", {31'h0, berr}, 32'h0);
    @(posedge clk); #1;
    rst = 0; rs = 2'b00;

    // Best-case load
    fixed_rd = 32'hDEADBEEF;
    issue(1'b0, 2'b01, 3'b010, 32'h100, 32'h0, st);
    chk("lw_stalls", st, 32'd3);
    chk("lw_data", rd_data, 32'hDEADBEEF);

    // Extraction
    fixed_rd = 32'h80FFFFFF;
    issue(1'b0, 2'b01, 3'b000, 32'h103, 32'h0, st);
    chk("lb_data", rd_data, 32'hFFFFFF80);
    issue(1'b0, 2'b01, 3'b100, 32'h103, 32'h0, st);
    chk("lbu_data", rd_data, 32'h00000080);
    fixed_rd = 32'hBEEF0000;
    issue(1'b0, 2'b01, 3'b101, 32'h102, 32'h0, st);
    chk("lhu_data", rd_data, 32'h0000BEEF);

    // Stores
    issue(1'b1, 2'b00, 3'b000, 32'h201, 32'h12345678, st);
    issue(1'b1, 2'b00, 3'b001, 32'h202, 32'h12345678, st);
    chk("store_keeps_rd", rd_data, 32'h0000BEEF);

    // Misaligned
    issue(1'b0, 2'b01, 3'b010, 32'h102, 32'h0, st);
    chk("mis_lw_stalls", st, 32'd0);
    issue(1'b1, 2'b00, 3'b001, 32'h301, 32'h0, st);

    // Withheld grant, back-to-back
    gd_min = 5; gd_max = 5; rand_rd = 1;
    issue(1'b0, 2'b01, 3'b010, 32'h400, 32'h0, st);
    chk("slow_gnt_stalls", st, 32'd8);
    issue(1'b1, 2'b00, 3'b010, 32'h404, 32'hCAFEF00D, st);

    // Reset in WAIT, then a late response
    bus_auto = 0;
    mw = 0; rs = 2'b01; f3 = 3'b010; alu = 32'h600;
    exp_q.push_back(model_req(1'b0, 32'h600, 3'b010, 32'h0));
    @(posedge clk); #1;
    chk("rstw_req", {31'h0, breq}, 32'h1);
    gnt = 1;
    @(posedge clk); #1;
    gnt = 0;
    @(posedge clk); #1;
    rst = 1; rs = 2'b00;
    @(posedge clk); #1;
    rst = 0; rvalid = 1; rdata = 32'h12345678;
    @(posedge clk); #1;
    rvalid = 0;
    @(negedge clk);
    chk("rstw_req_low", {31'h0, breq}, 32'h0);
    chk("rstw_rdata", rd_data, 32'h0);
    chk("rstw_stall", {31'h0, stall}, 32'h0);
    bus_auto = 1;

    // Timeout instance
    @(posedge clk); #1;
    t_rs = 2'b01; t_f3 = 3'b010; t_alu = 32'h500;
    @(posedge clk); #1;
    t_gnt = 1;
    @(posedge clk); #1;
    t_gnt = 0;
    n = 0;
    while (!t_berr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("to_err_pulse", {31'h0, t_berr}, 32'h1);
    chk("to_latency", {31'h0, n >= 4 && n <= 7}, 32'h1);
    chk("to_stall_low", {31'h0, t_stall}, 32'h0);
    chk("to_rd_keep", t_rd, 32'h0);
    @(posedge clk); #1;
    t_rs = 2'b00;
    @(negedge clk);
    chk("to_err_oneshot", {31'h0, t_berr}, 32'h0);
    chk("to_idle_stall", {31'h0, t_stall}, 32'h0);

    // Random traffic
    @(posedge clk); #1;
    gd_min = 0; gd_max = 3; rv_min = 1; rv_max = 4;
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(9, 0);
      if (n <= 4) begin
        m = 0; r2 = 2'b01; f = ld_f3[$urandom_range(4, 0)];
      end else if (n <= 7) begin
        m = 1; r2 = 2'($urandom_range(3, 0)); f = 3'($urandom_range(2, 0));
      end else if (n == 8) begin
        m = 1'($urandom_range(1, 0)); r2 = 2'b01; f = bad_f3[$urandom_range(2, 0)];
      end else begin
        m = 0; r2 = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b00; f = 3'($urandom_range(7, 0));
      end
      issue(m, r2, f, $urandom, $urandom, st);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
